// File: rtl/mem_issue_queue_if.sv
// Bundle between dispatch/CDB/load-store unit and the memory issue queue.
// The queue sits on the slave side; the surrounding pipeline drives the master side.
interface mem_issue_queue_if;
    logic        flush;
    logic        in_valid;
    logic        in_is_ld;
    logic [15:0] in_base_val;
    logic [5:0]  in_base_tag;
    logic        in_base_rdy;
    logic [15:0] in_data_val;
    logic [5:0]  in_data_tag;
    logic        in_data_rdy;
    logic [15:0] in_offset;
    logic [5:0]  in_rob;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        load_stall;
    logic        q_full;
    logic        out_valid;
    logic        out_is_ld;
    logic [15:0] out_data;
    logic [15:0] out_location;
    logic [5:0]  out_rob;

    modport master (
        output flush, in_valid, in_is_ld, in_base_val, in_base_tag, in_base_rdy,
               in_data_val, in_data_tag, in_data_rdy, in_offset, in_rob,
               cdb_valid, cdb_tag, cdb_data, load_stall,
        input  q_full, out_valid, out_is_ld, out_data, out_location, out_rob
    );

    modport slave (
        input  flush, in_valid, in_is_ld, in_base_val, in_base_tag, in_base_rdy,
               in_data_val, in_data_tag, in_data_rdy, in_offset, in_rob,
               cdb_valid, cdb_tag, cdb_data, load_stall,
        output q_full, out_valid, out_is_ld, out_data, out_location, out_rob
    );
endinterface

// File: rtl/mem_issue_queue.sv
// In-order memory-op issue queue: waits for CDB operands, then issues one op per
// cycle from the head with its effective address to the load/store unit.
module mem_issue_queue #(
    parameter int DEPTH = 8
) (
    input logic               clk,
    input logic               rst,
    mem_issue_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic        is_ld;
        logic [15:0] base_val;
        logic [5:0]  base_tag;
        logic        base_rdy;
        logic [15:0] data_val;
        logic [5:0]  data_tag;
        logic        data_rdy;
        logic [15:0] offset;
        logic [5:0]  rob;
    } entry_t;

    entry_t           ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             out_is_ld_q, out_is_ld_d;
    logic [15:0]      out_data_q, out_data_d;
    logic [15:0]      out_location_q, out_location_d;
    logic [5:0]       out_rob_q, out_rob_d;

    logic   full_s, enq_s, iss_s, head_rdy_s, base_hit_s, data_hit_s;
    entry_t head_e_s, new_e_s;

    assign full_s            = (count_q == CW'(DEPTH));
    assign bus.q_full        = full_s;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_is_ld     = out_is_ld_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_location  = out_location_q;
    assign bus.out_rob       = out_rob_q;

    // Enqueue/issue decision, incoming-entry capture and next-state computation.
    always_comb begin
        head_e_s   = ent_q[head_q];
        enq_s      = bus.in_valid && !full_s;
        head_rdy_s = (count_q != {CW{1'b0}}) && head_e_s.base_rdy &&
                     (head_e_s.is_ld || head_e_s.data_rdy);
        iss_s      = head_rdy_s && !bus.load_stall;

        // An operand broadcast in the dispatch cycle would otherwise be missed forever.
        base_hit_s = bus.cdb_valid && !bus.in_base_rdy && (bus.cdb_tag == bus.in_base_tag);
        data_hit_s = bus.cdb_valid && !bus.in_data_rdy && (bus.cdb_tag == bus.in_data_tag);
        new_e_s.is_ld    = bus.in_is_ld;
        new_e_s.base_val = base_hit_s ? bus.cdb_data : bus.in_base_val;
        new_e_s.base_tag = bus.in_base_tag;
        new_e_s.base_rdy = bus.in_base_rdy || base_hit_s;
        new_e_s.data_val = data_hit_s ? bus.cdb_data : bus.in_data_val;
        new_e_s.data_tag = bus.in_data_tag;
        new_e_s.data_rdy = bus.in_data_rdy || data_hit_s;
        new_e_s.offset   = bus.in_offset;
        new_e_s.rob      = bus.in_rob;

        head_d = iss_s ? head_q + PW'(1) : head_q;
        tail_d = enq_s ? tail_q + PW'(1) : tail_q;
        case ({enq_s, iss_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        out_valid_d    = iss_s;
        out_is_ld_d    = iss_s ? head_e_s.is_ld : 1'b0;
        out_rob_d      = iss_s ? head_e_s.rob : 6'd0;
        out_location_d = iss_s ? (head_e_s.base_val + head_e_s.offset) : 16'h0000;
        out_data_d     = (iss_s && !head_e_s.is_ld) ? head_e_s.data_val : 16'h0000;
    end

    // Pointers, occupancy, entry-valid bits and the registered issue port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            vld_q          <= '0;
            out_valid_q    <= 1'b0;
            out_is_ld_q    <= 1'b0;
            out_data_q     <= 16'h0000;
            out_location_q <= 16'h0000;
            out_rob_q      <= 6'd0;
        end else if (bus.flush) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            vld_q          <= '0;
            out_valid_q    <= 1'b0;
            out_is_ld_q    <= 1'b0;
            out_data_q     <= 16'h0000;
            out_location_q <= 16'h0000;
            out_rob_q      <= 6'd0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            if (iss_s) vld_q[head_q] <= 1'b0;
            if (enq_s) vld_q[tail_q] <= 1'b1;
            out_valid_q    <= out_valid_d;
            out_is_ld_q    <= out_is_ld_d;
            out_data_q     <= out_data_d;
            out_location_q <= out_location_d;
            out_rob_q      <= out_rob_d;
        end
    end

    // Entry storage: CDB wakeup of waiting operands, then the enqueue write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.cdb_valid && vld_q[i]) begin
                if (!ent_q[i].base_rdy && (ent_q[i].base_tag == bus.cdb_tag)) begin
                    ent_q[i].base_val <= bus.cdb_data;
                    ent_q[i].base_rdy <= 1'b1;
                end
                if (!ent_q[i].data_rdy && (ent_q[i].data_tag == bus.cdb_tag)) begin
                    ent_q[i].data_val <= bus.cdb_data;
                    ent_q[i].data_rdy <= 1'b1;
                end
            end
        end
        if (enq_s && !bus.flush && !rst) ent_q[tail_q] <= new_e_s;
    end
endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue: stimulus pushes expected issues into a
// scoreboard queue, an independent monitor checks every out_valid cycle.
module tb_mem_issue_queue;
    logic clk;
    logic rst;
    mem_issue_queue_if bus ();

    mem_issue_queue #(.DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        is_ld;
        logic [15:0] data;
        logic [15:0] loc;
        logic [5:0]  rob;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic ld, input logic [15:0] d, input logic [15:0] l, input logic [5:0] r);
        exp_t e;
        e.is_ld = ld; e.data = d; e.loc = l; e.rob = r;
        exp_q.push_back(e);
    endtask

    // Drives one dispatch for a single cycle (called at a falling edge).
    task automatic enq(input logic ld, input logic [15:0] bv, input logic [5:0] bt, input logic br,
                       input logic [15:0] dv, input logic [5:0] dt, input logic dr,
                       input logic [15:0] off, input logic [5:0] rob);
        bus.in_valid = 1'b1; bus.in_is_ld = ld;
        bus.in_base_val = bv; bus.in_base_tag = bt; bus.in_base_rdy = br;
        bus.in_data_val = dv; bus.in_data_tag = dt; bus.in_data_rdy = dr;
        bus.in_offset = off; bus.in_rob = rob;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Monitor: every presented issue must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (bus.out_valid === 1'b1) begin
            exp_t e;
            exp_t a;
            a.is_ld = bus.out_is_ld; a.data = bus.out_data;
            a.loc = bus.out_location; a.rob = bus.out_rob;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue actual=%0h required=none", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL issue_rob%0d actual=%0h required=%0h", e.rob, a, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_is_ld = 1'b0;
        bus.in_base_val = 16'h0000; bus.in_base_tag = 6'd0; bus.in_base_rdy = 1'b0;
        bus.in_data_val = 16'h0000; bus.in_data_tag = 6'd0; bus.in_data_rdy = 1'b0;
        bus.in_offset = 16'h0000; bus.in_rob = 6'd0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = 6'd0; bus.cdb_data = 16'h0000;
        bus.load_stall = 1'b0;
        idle(2);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_loc", 32'(bus.out_location), 32'd0);
        chk("rst_out_rob", 32'(bus.out_rob), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_is_ld", 32'(bus.out_is_ld), 32'd0);
        chk("rst_q_full", 32'(bus.q_full), 32'd0);
        rst = 1'b0;
        idle(1);
        chk("post_rst_count", 32'(dut.count_q), 32'd0);

        // Basic ready load: visible the cycle after enqueue, gone the cycle after.
        push_exp(1'b1, 16'h0000, 16'h1010, 6'd5);
        enq(1'b1, 16'h1000, 6'd0, 1'b1, 16'h0000, 6'd0, 1'b0, 16'h0010, 6'd5);
        chk("t1_latency", 32'(bus.out_valid), 32'd0);
        idle(1);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        idle(1);
        chk("t1_out_valid_drop", 32'(bus.out_valid), 32'd0);

        // Store waiting on base tag 3 blocks the ready load behind it.
        push_exp(1'b0, 16'hBEEF, 16'h2004, 6'd10);
        push_exp(1'b1, 16'h0000, 16'h0108, 6'd11);
        enq(1'b0, 16'h0000, 6'd3, 1'b0, 16'hBEEF, 6'd0, 1'b1, 16'h0004, 6'd10);
        enq(1'b1, 16'h0100, 6'd0, 1'b1, 16'h0000, 6'd0, 1'b0, 16'h0008, 6'd11);
        for (int k = 0; k < 3; k++) begin
            chk("t2_blocked", 32'(bus.out_valid), 32'd0);
            idle(1);
        end
        chk("t2_count", 32'(dut.count_q), 32'd2);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd3; bus.cdb_data = 16'h2000;
        idle(1);
        bus.cdb_valid = 1'b0;
        idle(1);
        chk("t2_a_issued", 32'(bus.out_rob), 32'd10);
        idle(1);
        chk("t2_b_issued", 32'(bus.out_rob), 32'd11);
        idle(1);

        // Operand arriving on the CDB in the very dispatch cycle.
        push_exp(1'b1, 16'h0000, 16'h0045, 6'd12);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd7; bus.cdb_data = 16'h0042;
        enq(1'b1, 16'h0000, 6'd7, 1'b0, 16'h0000, 6'd0, 1'b0, 16'h0003, 6'd12);
        bus.cdb_valid = 1'b0;
        idle(2);

        // Fill under stall, then refuse extra dispatches while full.
        bus.load_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_exp(1'b1, 16'h0000, 16'h0300 + 16'(i), 6'(20 + i));
            enq(1'b1, 16'h0300, 6'd0, 1'b1, 16'h0000, 6'd0, 1'b0, 16'(i), 6'(20 + i));
        end
        chk("t4_q_full", 32'(bus.q_full), 32'd1);
        chk("t4_stalled", 32'(bus.out_valid), 32'd0);
        enq(1'b1, 16'h0F00, 6'd0, 1'b1, 16'h0000, 6'd0, 1'b0, 16'h0000, 6'd28);
        chk("t4_ninth_refused", 32'(dut.count_q), 32'd8);
        bus.load_stall = 1'b0;
        enq(1'b1, 16'h0F00, 6'd0, 1'b1, 16'h0000, 6'd0, 1'b0, 16'h0000, 6'd29);
        chk("t4_full_enq_issue", 32'(dut.count_q), 32'd7);
        idle(9);
        chk("t4_drained", 32'(dut.count_q), 32'd0);
        chk("t4_not_full", 32'(bus.q_full), 32'd0);
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b0, 16'hA000 + 16'(i), 16'h0500 + 16'(i), 6'(30 + i));
            enq(1'b0, 16'h0500, 6'd0, 1'b1, 16'hA000 + 16'(i), 6'd0, 1'b1, 16'(i), 6'(30 + i));
        end
        idle(3);

        // Stall with a ready head, plus address wraparound.
        bus.load_stall = 1'b1;
        push_exp(1'b1, 16'h0000, 16'h0010, 6'd40);
        enq(1'b1, 16'hFFF0, 6'd0, 1'b1, 16'h0000, 6'd0, 1'b0, 16'h0020, 6'd40);
        idle(1);
        chk("t5_stall_ov", 32'(bus.out_valid), 32'd0);
        chk("t5_stall_count", 32'(dut.count_q), 32'd1);
        bus.load_stall = 1'b0;
        idle(2);

        // Flush with waiting entries and a simultaneous dispatch.
        bus.load_stall = 1'b1;
        for (int i = 0; i < 4; i++)
            enq(1'b1, 16'h0000, 6'd9, 1'b0, 16'h0000, 6'd0, 1'b0, 16'h0001, 6'(50 + i));
        chk("t6_count4", 32'(dut.count_q), 32'd4);
        bus.load_stall = 1'b0;
        bus.flush = 1'b1;
        enq(1'b1, 16'h1234, 6'd0, 1'b1, 16'h0000, 6'd0, 1'b0, 16'h0000, 6'd55);
        bus.flush = 1'b0;
        chk("t6_flush_count", 32'(dut.count_q), 32'd0);
        chk("t6_flush_ov", 32'(bus.out_valid), 32'd0);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd9; bus.cdb_data = 16'h7777;
        idle(1);
        bus.cdb_valid = 1'b0;
        idle(2);
        chk("t6_no_issue", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset while an issue is on the output.
        push_exp(1'b1, 16'h0000, 16'h0066, 6'd60);
        enq(1'b1, 16'h0060, 6'd0, 1'b1, 16'h0000, 6'd0, 1'b0, 16'h0006, 6'd60);
        @(posedge clk);
        #3;
        chk("t7_pre_rst_ov", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t7_async_ov", 32'(bus.out_valid), 32'd0);
        chk("t7_async_loc", 32'(bus.out_location), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_issue_queue.md
# mem_issue_queue

In-order issue queue for memory operations, directly upstream of the load/store unit. It holds loads and stores from dispatch until their operands arrive on the common data bus (CDB). It then computes the effective address and sends one operation per cycle to the load/store unit in program order. It honours the load/store unit's stall and the global pipeline flush.

## Interface
- DEPTH, 8: number of queue entries; a power of two, at least 2.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  dispatch offers one memory op this cycle.
- in_is_ld  input  1  1 = load, 0 = store.
- in_base_val / in_base_tag / in_base_rdy  input  16/6/1  base register value, ROB tag, and value-present flag.
- in_data_val / in_data_tag / in_data_rdy  input  16/6/1  store data value, tag, and present flag; ignored for loads.
- in_offset  input  16  immediate offset.
- in_rob  input  6  ROB index of the op.
- cdb_valid / cdb_tag / cdb_data  input  1/6/16  result broadcast.
- load_stall  input  1  load/store unit cannot accept an op.
- q_full  output  1  count == DEPTH; dispatch must not assert in_valid.
- out_valid  output  1  registered; the op below is valid this cycle.
- out_is_ld / out_data / out_location / out_rob  output  1/16/16/6  drive the load/store unit's is_ld, data, location and ROBloc inputs.

## Operation
- Circular buffer with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- Each entry holds: is_ld, base {val, tag, rdy}, data {val, tag, rdy}, offset, and rob.
- **Enqueue** occurs when in_valid && !q_full. The entry is written at tail and tail advances.
  - Capture at entry: if cdb_valid and cdb_tag equals a not-ready incoming tag, the entry stores cdb_data with rdy=1.
- **Wakeup**: every valid entry with rdy=0 and a tag equal to cdb_tag (while cdb_valid) latches cdb_data and sets rdy=1. Base and data operands are checked independently; one broadcast may wake both.
- **Head ready** means count>0 && base.rdy && (is_ld || data.rdy).
  - Only the head may issue; there is no bypass of an older non-ready op.
- **Issue** occurs on head ready && !load_stall. The head pops and the output registers load:
  - out_location = base.val + offset, truncated to 16 bits (wrap, no carry out);
  - out_data = data.val for stores, 0 for loads;
  - out_is_ld and out_rob taken from the entry;
  - out_valid = 1.
- If no issue occurs on an edge, out_valid becomes 0. Outputs are never held across cycles; the load/store unit samples them every cycle.
- **Count** updates by +enqueue − issue. Simultaneous enqueue and issue leaves count unchanged.
  - When full, enqueue is refused even if an issue occurs in the same cycle, because q_full is based on the current count.
- **Flush** has priority over enqueue, wakeup and issue. It sets head=tail=0, count=0 and out_valid=0, and all entries become invalid.
- **rst** clears everything to the flushed state immediately, including in the middle of an operation.

## Timing
- Reset values:
  - out_valid=0, out_is_ld=0, out_data=0, out_location=0, out_rob=0;
  - q_full=0, head=tail=count=0.
- Minimum latency from dispatch to out_valid is 1 cycle: an op enqueued at edge N with ready operands issues at edge N+1 and is visible in cycle N+1.
- CDB wakeup at edge N lets the op issue at edge N+1.
- load_stall is sampled combinationally in the issue decision. While it is high, no pop occurs and out_valid=0 on the next cycle.
- Throughput is one issue per cycle while the head stays ready.
- A flush asserted in the same cycle as in_valid drops the incoming op.
- q_full is combinational from count.

## Test plan
- **Reset and basic load:** after rst, enqueue a load with base=0x1000 (rdy), offset=0x0010, rob=5 → next cycle out_valid=1, out_is_ld=1, out_location=0x1010, out_rob=5; the following cycle out_valid=0.
- **CDB wakeup and ordering:**
  - Enqueue store A (base tag 3, not ready; data ready 0xBEEF), then load B fully ready.
  - No issue until cdb_valid with tag=3, data=0x2000.
  - Then A issues with location=0x2000+offset and data=0xBEEF, and B issues on the following cycle.
- **Enqueue-cycle capture:** enqueue with base tag 7 not ready while cdb_tag=7, data=0x0042 in the same cycle → issues next cycle with location=0x0042+offset.
- **Full and wrap:**
  - With load_stall=1, enqueue 8 ops; q_full=1 and a 9th in_valid is ignored.
  - Release the stall → 8 issues in order with the correct rob values.
  - Enqueue 3 more → pointers wrap and ordering is preserved.
- **Stall and address wrap:**
  - load_stall=1 with the head ready → out_valid=0 and count is unchanged.
  - Base 0xFFF0 with offset 0x0020 → out_location=0x0010.
- **Flush and async reset:** with 4 entries queued, flush → next cycle count=0 and out_valid=0, and a later CDB broadcast issues nothing; asserting rst mid-issue clears out_valid without waiting for a clock edge.
